// File: rtl/stream_demux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_demux_pkg
// Description : Shared types and constants for the stream demultiplexer:
//               routing FSM state encoding and drop counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package stream_demux_pkg;

    // Routing FSM state, encoded as plain constants for legacy tool flows
    typedef logic [1:0] state_t;

    localparam state_t c_IDLE = 2'd0;  // waiting for the first beat of a packet
    localparam state_t c_FWD  = 2'd1;  // forwarding a packet to the latched channel
    localparam state_t c_DROP = 2'd2;  // swallowing a packet with an illegal select

    // Width of the saturating dropped-beat counter
    localparam int c_DROP_CNT_W = 16;

endpackage : stream_demux_pkg
`default_nettype wire

// File: rtl/stream_demux_slot.sv
`default_nettype none
// ============================================================================
// Module      : stream_demux_slot
// Description : One-entry registered holding stage (valid, data, last) for a
//               single demux output channel. A load replaces the entry even
//               while it is being drained, so a full slot with a ready
//               consumer sustains one beat per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_demux_slot #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_ready,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_last,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              r_last;

    // Load has priority over drain; data/last only change on a load so they
    // stay stable while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_last  <= i_last;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;

endmodule : stream_demux_slot
`default_nettype wire

// File: rtl/stream_demux_nx.sv
`default_nettype none
// ============================================================================
// Module      : stream_demux_nx
// Description : 1-to-NUM_OUT packet-locked stream demultiplexer. The select of
//               a packet's first beat picks the output channel for the whole
//               packet; packets with an out-of-range select are discarded,
//               flagged with a one-cycle err_sel pulse and counted beat by
//               beat in a saturating drop counter. Every channel has a
//               one-entry registered output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_demux_nx
    import stream_demux_pkg::*;
#(
    parameter  int DATA_W  = 8,
    parameter  int NUM_OUT = 4,
    localparam int SEL_W   = (NUM_OUT > 2) ? $clog2(NUM_OUT) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [DATA_W-1:0]         s_data,
    input  logic                      s_last,
    input  logic [SEL_W-1:0]          s_sel,
    output logic [NUM_OUT-1:0]        m_valid,
    input  logic [NUM_OUT-1:0]        m_ready,
    output logic [NUM_OUT*DATA_W-1:0] m_data,
    output logic [NUM_OUT-1:0]        m_last,
    output logic                      err_sel,
    output logic [c_DROP_CNT_W-1:0]   drop_cnt
);

    state_t                  r_state;
    logic [SEL_W-1:0]        r_sel;
    logic                    r_err;
    logic [c_DROP_CNT_W-1:0] r_drop_cnt;

    logic                    w_sel_legal;
    logic                    w_fwd;
    logic [SEL_W-1:0]        w_tgt;
    logic                    w_tgt_free;
    logic                    w_accept;
    logic                    w_discard;
    logic [NUM_OUT-1:0]      w_load;
    logic [NUM_OUT-1:0]      w_slot_valid;

    // A select is only meaningful when it names an existing channel; with a
    // non-power-of-two NUM_OUT the top codes are illegal.
    assign w_sel_legal = (32'(s_sel) < 32'(NUM_OUT));

    // Forwarding applies mid-packet, or on a first beat with a legal select.
    assign w_fwd = (r_state == c_FWD) || ((r_state == c_IDLE) && w_sel_legal);

    // Mid-packet the latched select wins; s_sel is only looked at in IDLE.
    assign w_tgt = (r_state == c_FWD) ? r_sel : s_sel;

    // Target slot can take a beat if empty or draining this cycle
    always_comb begin
        w_tgt_free = 1'b0;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (32'(w_tgt) == 32'(k)) begin
                w_tgt_free = !w_slot_valid[k] || m_ready[k];
            end
        end
    end

    // Discarded beats are always accepted; nothing is accepted during reset.
    assign s_ready   = !rst && (w_fwd ? w_tgt_free : 1'b1);
    assign w_accept  = s_valid && s_ready;
    assign w_discard = w_accept && !w_fwd;

    // One-hot load strobe toward the target slot
    always_comb begin
        w_load = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            w_load[k] = w_accept && w_fwd && (32'(w_tgt) == 32'(k));
        end
    end

    // Routing FSM: advances only on accepted beats; s_last always ends a packet
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_sel   <= '0;
        end else if (w_accept) begin
            case (r_state)
                c_IDLE: begin
                    if (w_sel_legal) begin
                        r_sel   <= s_sel;
                        r_state <= s_last ? c_IDLE : c_FWD;
                    end else begin
                        r_state <= s_last ? c_IDLE : c_DROP;
                    end
                end
                c_FWD, c_DROP: begin
                    if (s_last) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Error pulse: only the first beat of an illegal packet raises it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_accept && (r_state == c_IDLE) && !w_sel_legal;
        end
    end

    // Saturating count of every discarded beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_discard && (r_drop_cnt != {c_DROP_CNT_W{1'b1}})) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign err_sel  = r_err;
    assign drop_cnt = r_drop_cnt;

    for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_slot
        stream_demux_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk     (clk),
            .rst     (rst),
            .i_load  (w_load[gi]),
            .i_ready (m_ready[gi]),
            .i_data  (s_data),
            .i_last  (s_last),
            .o_valid (w_slot_valid[gi]),
            .o_data  (m_data[gi*DATA_W +: DATA_W]),
            .o_last  (m_last[gi])
        );
    end

    assign m_valid = w_slot_valid;

endmodule : stream_demux_nx
`default_nettype wire

// File: tb/tb_stream_demux_nx.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_demux_nx
// Description : Self-checking bench for stream_demux_nx. A 4-channel instance
//               covers routing, packet locking, backpressure, async reset and
//               randomized traffic against a queue-based model; a 3-channel
//               instance covers illegal selects and drop counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_stream_demux_nx;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid4;
    logic        s_valid3;
    logic [7:0]  s_data;
    logic        s_last;
    logic [1:0]  s_sel;
    logic [3:0]  m_ready;

    logic        s_ready4;
    logic [3:0]  m_valid4;
    logic [31:0] m_data4;
    logic [3:0]  m_last4;
    logic        err4;
    logic [15:0] drop4;

    logic        s_ready3;
    logic [2:0]  m_valid3;
    logic [23:0] m_data3;
    logic [2:0]  m_last3;
    logic        err3;
    logic [15:0] drop3;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    stream_demux_nx #(.DATA_W(8), .NUM_OUT(4)) dut4 (
        .clk(clk), .rst(rst), .s_valid(s_valid4), .s_ready(s_ready4),
        .s_data(s_data), .s_last(s_last), .s_sel(s_sel),
        .m_valid(m_valid4), .m_ready(m_ready), .m_data(m_data4), .m_last(m_last4),
        .err_sel(err4), .drop_cnt(drop4)
    );

    stream_demux_nx #(.DATA_W(8), .NUM_OUT(3)) dut3 (
        .clk(clk), .rst(rst), .s_valid(s_valid3), .s_ready(s_ready3),
        .s_data(s_data), .s_last(s_last), .s_sel(s_sel),
        .m_valid(m_valid3), .m_ready(m_ready[2:0]), .m_data(m_data3), .m_last(m_last3),
        .err_sel(err3), .drop_cnt(drop3)
    );

    task automatic test_reset();
        rst = 1'b1; s_valid4 = 1'b0; s_valid3 = 1'b0;
        s_data = 8'h00; s_last = 1'b0; s_sel = 2'd0; m_ready = 4'hF;
        #12;
        n_checks++;
        if (m_valid4 !== 4'b0 || m_data4 !== 32'h0 || m_last4 !== 4'b0 || err4 !== 1'b0 || drop4 !== 16'h0)
            $display("FAIL reset_out4 valid=%b data=%h last=%b err=%b drop=%h want all zero", m_valid4, m_data4, m_last4, err4, drop4);
        else n_pass++;
        n_checks++;
        if (s_ready4 !== 1'b0 || s_ready3 !== 1'b0)
            $display("FAIL reset_ready got %b/%b want 0/0", s_ready4, s_ready3);
        else n_pass++;
        n_checks++;
        if (m_valid3 !== 3'b0 || drop3 !== 16'h0 || err3 !== 1'b0)
            $display("FAIL reset_out3 valid=%b drop=%h err=%b want zero", m_valid3, drop3, err3);
        else n_pass++;
        @(negedge clk); rst = 1'b0; #1;
        n_checks++;
        if (s_ready4 !== 1'b1 || s_ready3 !== 1'b1)
            $display("FAIL post_reset_ready got %b/%b want 1/1", s_ready4, s_ready3);
        else n_pass++;
    endtask

    task automatic test_routing();
        m_ready = 4'hF;
        for (int ch = 0; ch < 4; ch++) begin
            for (int b = 0; b < 3; b++) begin
                @(negedge clk);
                s_valid4 = 1'b1; s_data = 8'hA0 + 8'(b); s_last = (b == 2); s_sel = 2'(ch);
                #1;
                n_checks++;
                if (s_ready4 !== 1'b1) $display("FAIL route_ready ch%0d b%0d got %b want 1", ch, b, s_ready4);
                else n_pass++;
                @(posedge clk); #1;
                n_checks++;
                if (m_valid4 !== 4'(1 << ch) || m_data4[ch*8 +: 8] !== 8'hA0 + 8'(b) || m_last4[ch] !== (b == 2))
                    $display("FAIL route_out ch%0d b%0d got v=%b d=%h l=%b want v=%b d=%h l=%b", ch, b,
                             m_valid4, m_data4[ch*8 +: 8], m_last4[ch], 4'(1 << ch), 8'hA0 + 8'(b), (b == 2));
                else n_pass++;
            end
        end
        @(negedge clk); s_valid4 = 1'b0; s_last = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (m_valid4 !== 4'b0) $display("FAIL route_drain got %b want 0000", m_valid4);
        else n_pass++;
    endtask

    task automatic test_sel_toggle();
        logic [1:0] sels [3];
        sels[0] = 2'd2; sels[1] = 2'd0; sels[2] = 2'd0;
        m_ready = 4'hF;
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            s_valid4 = 1'b1; s_data = 8'h50 + 8'(b); s_last = (b == 2); s_sel = sels[b];
            @(posedge clk); #1;
            n_checks++;
            if (m_valid4 !== 4'b0100 || m_data4[23:16] !== 8'h50 + 8'(b))
                $display("FAIL sel_lock b%0d got v=%b d=%h want v=0100 d=%h", b, m_valid4, m_data4[23:16], 8'h50 + 8'(b));
            else n_pass++;
        end
        @(negedge clk); s_valid4 = 1'b0; s_last = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        m_ready = 4'b1101;
        s_valid4 = 1'b1; s_data = 8'h11; s_last = 1'b0; s_sel = 2'd1;
        #1;
        n_checks++;
        if (s_ready4 !== 1'b1) $display("FAIL bp_first_ready got %b want 1", s_ready4);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (m_valid4 !== 4'b0010 || m_data4[15:8] !== 8'h11 || m_last4[1] !== 1'b0)
            $display("FAIL bp_first_out got v=%b d=%h l=%b want v=0010 d=11 l=0", m_valid4, m_data4[15:8], m_last4[1]);
        else n_pass++;
        @(negedge clk);
        s_data = 8'h22; s_last = 1'b1; s_sel = 2'd3;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if (s_ready4 !== 1'b0) $display("FAIL bp_stall_ready cyc%0d got %b want 0", i, s_ready4);
            else n_pass++;
            @(posedge clk); #1;
            n_checks++;
            if (m_valid4 !== 4'b0010 || m_data4[15:8] !== 8'h11 || m_last4[1] !== 1'b0)
                $display("FAIL bp_hold cyc%0d got v=%b d=%h l=%b want v=0010 d=11 l=0", i, m_valid4, m_data4[15:8], m_last4[1]);
            else n_pass++;
            @(negedge clk);
        end
        m_ready = 4'hF;
        #1;
        n_checks++;
        if (s_ready4 !== 1'b1) $display("FAIL bp_release_ready got %b want 1", s_ready4);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (m_valid4 !== 4'b0010 || m_data4[15:8] !== 8'h22 || m_last4[1] !== 1'b1)
            $display("FAIL bp_no_bubble got v=%b d=%h l=%b want v=0010 d=22 l=1", m_valid4, m_data4[15:8], m_last4[1]);
        else n_pass++;
        @(negedge clk); s_valid4 = 1'b0; s_last = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (m_valid4 !== 4'b0) $display("FAIL bp_drain got %b want 0000", m_valid4);
        else n_pass++;
    endtask

    task automatic test_illegal();
        m_ready = 4'hF;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            s_valid3 = 1'b1; s_data = 8'($urandom); s_last = (b == 3);
            s_sel = (b == 0) ? 2'd3 : 2'($urandom_range(0, 3));
            #1;
            n_checks++;
            if (s_ready3 !== 1'b1) $display("FAIL ill_ready b%0d got %b want 1", b, s_ready3);
            else n_pass++;
            @(posedge clk); #1;
            n_checks++;
            if (m_valid3 !== 3'b0 || err3 !== (b == 0))
                $display("FAIL ill_out b%0d got v=%b err=%b want v=000 err=%b", b, m_valid3, err3, (b == 0));
            else n_pass++;
        end
        @(negedge clk); s_valid3 = 1'b0; s_last = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (err3 !== 1'b0 || drop3 !== 16'd4)
            $display("FAIL ill_count got err=%b drop=%0d want err=0 drop=4", err3, drop3);
        else n_pass++;
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            s_valid3 = 1'b1; s_data = 8'h70 + 8'(b); s_last = (b == 1);
            s_sel = (b == 0) ? 2'd0 : 2'd3;
            @(posedge clk); #1;
            n_checks++;
            if (m_valid3 !== 3'b001 || m_data3[7:0] !== 8'h70 + 8'(b) || m_last3[0] !== (b == 1) || err3 !== 1'b0)
                $display("FAIL ill_recover b%0d got v=%b d=%h l=%b err=%b want v=001 d=%h l=%b err=0",
                         b, m_valid3, m_data3[7:0], m_last3[0], err3, 8'h70 + 8'(b), (b == 1));
            else n_pass++;
        end
        @(negedge clk); s_valid3 = 1'b0; s_last = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_async_reset();
        logic [1:0] sels [3];
        sels[0] = 2'd0; sels[1] = 2'd1; sels[2] = 2'd2;
        m_ready = 4'h0;
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            s_valid4 = 1'b1; s_data = 8'h31 + 8'(b); s_last = (b != 2); s_sel = sels[b];
            @(posedge clk);
        end
        @(negedge clk); s_valid4 = 1'b0; s_last = 1'b0; #1;
        n_checks++;
        if (m_valid4 !== 4'b0111) $display("FAIL ar_fill got %b want 0111", m_valid4);
        else n_pass++;
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (m_valid4 !== 4'b0 || s_ready4 !== 1'b0 || drop3 !== 16'h0)
            $display("FAIL ar_immediate got v=%b rdy=%b drop3=%h want v=0000 rdy=0 drop3=0000", m_valid4, s_ready4, drop3);
        else n_pass++;
        @(negedge clk); rst = 1'b0;
        m_ready = 4'hF;
        s_valid4 = 1'b1; s_data = 8'h44; s_last = 1'b1; s_sel = 2'd1;
        @(posedge clk); #1;
        n_checks++;
        if (m_valid4 !== 4'b0010 || m_data4[15:8] !== 8'h44 || m_last4[1] !== 1'b1)
            $display("FAIL ar_first_beat got v=%b d=%h l=%b want v=0010 d=44 l=1", m_valid4, m_data4[15:8], m_last4[1]);
        else n_pass++;
        @(negedge clk); s_valid4 = 1'b0; s_last = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_random();
        logic [8:0] q [4][$];
        bit         in_pkt = 1'b0;
        int         dest = 0;
        int         t;
        bit         exp_rdy;
        logic [3:0] exp_v;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            s_valid4 = ($urandom_range(0, 9) < 7);
            s_data   = 8'($urandom);
            s_last   = ($urandom_range(0, 3) == 0);
            s_sel    = 2'($urandom);
            m_ready  = 4'($urandom);
            #1;
            for (int k = 0; k < 4; k++) exp_v[k] = (q[k].size() != 0);
            n_checks++;
            if (m_valid4 !== exp_v) $display("FAIL rnd_valid cyc%0d got %b want %b", cyc, m_valid4, exp_v);
            else n_pass++;
            for (int k = 0; k < 4; k++) begin
                if (q[k].size() != 0) begin
                    n_checks++;
                    if ({m_last4[k], m_data4[k*8 +: 8]} !== q[k][0])
                        $display("FAIL rnd_data cyc%0d ch%0d got %h want %h", cyc, k, {m_last4[k], m_data4[k*8 +: 8]}, q[k][0]);
                    else n_pass++;
                end
            end
            t = in_pkt ? dest : int'(s_sel);
            exp_rdy = (q[t].size() == 0) || m_ready[t];
            n_checks++;
            if (s_ready4 !== exp_rdy) $display("FAIL rnd_ready cyc%0d got %b want %b", cyc, s_ready4, exp_rdy);
            else n_pass++;
            for (int k = 0; k < 4; k++) begin
                if (q[k].size() != 0 && m_ready[k]) void'(q[k].pop_front());
            end
            if (s_valid4 && exp_rdy) begin
                q[t].push_back({s_last, s_data});
                in_pkt = !s_last;
                dest   = t;
            end
            @(posedge clk);
        end
        @(negedge clk); s_valid4 = 1'b0; s_last = 1'b0;
    endtask

    task automatic test_saturation();
        @(negedge clk);
        m_ready = 4'hF; s_valid3 = 1'b1; s_sel = 2'd3; s_last = 1'b1; s_data = 8'h5A;
        repeat (65534) @(posedge clk);
        #1;
        n_checks++;
        if (drop3 !== 16'hFFFE || err3 !== 1'b1)
            $display("FAIL sat_near got drop=%h err=%b want drop=fffe err=1", drop3, err3);
        else n_pass++;
        repeat (6) @(posedge clk);
        #1;
        n_checks++;
        if (drop3 !== 16'hFFFF) $display("FAIL sat_hold got %h want ffff", drop3);
        else n_pass++;
        @(negedge clk); s_valid3 = 1'b0; s_last = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (drop3 !== 16'hFFFF || err3 !== 1'b0 || m_valid3 !== 3'b0)
            $display("FAIL sat_idle got drop=%h err=%b v=%b want ffff 0 000", drop3, err3, m_valid3);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_routing();
        test_sel_toggle();
        test_backpressure();
        test_illegal();
        test_async_reset();
        test_random();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_stream_demux_nx
`default_nettype wire
